// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encodings and default width.
package serial_ripple_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_ripple_subtractor_if.sv
// Request/result bundle between a controlling FSM (master) and the subtractor (slave).
interface serial_ripple_subtractor_if
    import serial_ripple_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             bin_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] d_o;
    logic             bout_o;
    logic             v_o;

    modport master (
        output start_i, a_i, b_i, bin_i,
        input  busy_o, done_o, d_o, bout_o, v_o
    );

    modport slave (
        input  start_i, a_i, b_i, bin_i,
        output busy_o, done_o, d_o, bout_o, v_o
    );
endinterface

// File: rtl/serial_ripple_subtractor_full_sub.sv
// One-bit full subtractor cell: d = a - b - bi, bo = borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial D = A - B - Bin, LSB first, one full_sub cell plus a borrow flop.
module serial_ripple_subtractor
    import serial_ripple_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_ripple_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
    logic             brw_q, brw_d, bout_q, bout_d, v_q, v_d;
    logic             diff, bo;

    full_sub u_fs (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .bi (brw_q),
        .d  (diff),
        .bo (bo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        d_d     = d_q;
        bout_d  = bout_q;
        v_d     = v_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    a_d     = bus.a_i;
                    b_d     = bus.b_i;
                    brw_d   = bus.bin_i;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                res_d = {diff, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                brw_d = bo;
                cnt_d = cnt_q + CW'(1);
                // On the last step the operand LSBs are the original sign bits.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    d_d     = {diff, res_q[WIDTH-1:1]};
                    bout_d  = bo;
                    v_d     = (a_q[0] ^ b_q[0]) & (diff ^ a_q[0]);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
        end
    end

    assign bus.busy_o = (state_q != ST_IDLE);
    assign bus.done_o = (state_q == ST_DONE);
    assign bus.d_o    = d_q;
    assign bus.bout_o = bout_q;
    assign bus.v_o    = v_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed bench for serial_ripple_subtractor (WIDTH=4) with a cycle-level reference model.
module tb_serial_ripple_subtractor;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    bit   cmp_en;

    serial_ripple_subtractor_if #(.WIDTH(W)) bus ();

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference result straight from the arithmetic definition.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int          ia, ib, ib2;
        logic [W-1:0] d;
        logic        bout, v;
        ia   = int'(a);
        ib   = int'(b);
        ib2  = ib + int'(bin);
        d    = W'((ia - ib2 + 64) % (1 << W));
        bout = (ia < ib2);
        v    = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
        return {bout, v, d};
    endfunction

    // Model: an accepted op keeps the block busy for W+1 cycles, the last being done.
    int           m_left;
    logic [W-1:0] m_d, p_d;
    logic         m_bout, m_v, p_bout, p_v;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_d    <= '0;
            m_bout <= 1'b0;
            m_v    <= 1'b0;
        end else if (m_left == 0) begin
            if (bus.start_i) begin
                m_left <= W + 1;
                {p_bout, p_v, p_d} <= ref_sub(bus.a_i, bus.b_i, bus.bin_i);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_d    <= p_d;
                m_bout <= p_bout;
                m_v    <= p_v;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", 32'(bus.busy_o), 32'(m_left != 0));
            check("cyc_done", 32'(bus.done_o), 32'(m_left == 1));
            check("cyc_d",    32'(bus.d_o),    32'(m_d));
            check("cyc_bout", 32'(bus.bout_o), 32'(m_bout));
            check("cyc_v",    32'(bus.v_o),    32'(m_v));
        end
    end

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input logic [W-1:0] ed, input logic eb, input logic ev);
        int n;
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.a_i = a; bus.b_i = b; bus.bin_i = bin;
        @(posedge clk); n = 1; #1;
        bus.start_i = 1'b0;
        while (!bus.done_o && n < 20) begin
            @(posedge clk); n++; #1;
        end
        check({name, "_latency"}, 32'(n), 32'(W + 1));
        check({name, "_d"},    32'(bus.d_o),    32'(ed));
        check({name, "_bout"}, 32'(bus.bout_o), 32'(eb));
        check({name, "_v"},    32'(bus.v_o),    32'(ev));
        @(posedge clk); #1;
        check({name, "_done_1cyc"}, 32'(bus.done_o), 32'd0);
        check({name, "_idle"},      32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        int ndone;
        logic [W-1:0] dcap;
        n_checks = 0; n_pass = 0; cmp_en = 1'b0;
        bus.start_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.bin_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_d",    32'(bus.d_o),    32'd0);
        check("rst_bout", 32'(bus.bout_o), 32'd0);
        check("rst_v",    32'(bus.v_o),    32'd0);
        cmp_en = 1'b1;

        do_op("t1_7m3",  4'd7,  4'd3,  1'b0, 4'h4, 1'b0, 1'b0);
        do_op("t2_3m7",  4'd3,  4'd7,  1'b0, 4'hC, 1'b1, 1'b0);
        do_op("t3_8m1",  4'd8,  4'd1,  1'b0, 4'h7, 1'b0, 1'b1);
        do_op("t4_0m0b", 4'd0,  4'd0,  1'b1, 4'hF, 1'b1, 1'b0);
        do_op("tx_FmFb", 4'hF,  4'hF,  1'b1, 4'hF, 1'b1, 1'b0);
        do_op("tx_4mC",  4'h4,  4'hC,  1'b0, 4'h8, 1'b1, 1'b1);

        // Start while busy is dropped, and input changes mid-op are ignored.
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.a_i = 4'd5; bus.b_i = 4'd2; bus.bin_i = 1'b0;
        @(posedge clk); #1 bus.start_i = 1'b0;
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.a_i = 4'd9; bus.b_i = 4'd9;
        @(posedge clk); #1 bus.start_i = 1'b0;
        ndone = 0; dcap = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.done_o) begin ndone++; dcap = bus.d_o; end
        end
        check("t5_ndone", 32'(ndone), 32'd1);
        check("t5_d",     32'(dcap),  32'h3);
        check("t5_idle",  32'(bus.busy_o), 32'd0);

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.a_i = 4'd7; bus.b_i = 4'd3; bus.bin_i = 1'b0;
        @(posedge clk); #1 bus.start_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("t6_busy_pre", 32'(bus.busy_o), 32'd1);
        rst = 1'b1; #1;
        check("t6_busy", 32'(bus.busy_o), 32'd0);
        check("t6_done", 32'(bus.done_o), 32'd0);
        check("t6_d",    32'(bus.d_o),    32'd0);
        check("t6_bout", 32'(bus.bout_o), 32'd0);
        check("t6_v",    32'(bus.v_o),    32'd0);
        @(posedge clk); #1 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done_o) ndone++;
        end
        check("t6_no_done", 32'(ndone), 32'd0);
        do_op("t6_after", 4'd7, 4'd3, 1'b0, 4'h4, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
